// File: rtl/i2c_codec_target.sv
// I2C target modelling the audio codec control port: 7-bit device address,
// then {reg_addr[6:0], data[8]} and data[7:0]; local register bank with read-back.
module i2c_codec_target #(
  parameter logic [6:0]  DEVICE_ADDR = 7'h1A,
  parameter int unsigned REG_COUNT   = 19
) (
  input  logic       board_clk,
  input  logic       reset_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       wr_strobe,
  output logic [6:0] wr_addr,
  output logic [8:0] wr_data,
  output logic       busy,
  input  logic [6:0] dbg_rd_addr,
  output logic [8:0] dbg_rd_data
);

  localparam int unsigned AW       = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
  localparam logic [6:0]  REG_LAST = 7'(REG_COUNT - 1);

  typedef enum logic [3:0] {
    IDLE, DEV_ADDR, DEV_ACK, WR_B0, ACK0, WR_B1, ACK1, RD_BYTE, RD_MACK, IGNORE
  } state_t;

  state_t     state;
  logic [2:0] scl_p;
  logic [2:0] sda_p;
  logic [3:0] bit_cnt;
  logic [6:0] shift;
  logic       rw;
  logic       d8;
  logic [6:0] ptr;
  logic       byte_idx;
  logic [8:0] regs [REG_COUNT];

  logic       scl_rise;
  logic       scl_fall;
  logic       start_det;
  logic       stop_det;
  logic       sda_bit;
  logic [7:0] rx_byte;
  logic [8:0] cur_reg;
  logic [7:0] tx_byte;
  logic [2:0] tx_bit_idx;

  // Two synchronizer flops plus one history flop; idle-bus reset value avoids false edges.
  always_ff @(posedge board_clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_p <= '1;
      sda_p <= '1;
    end else begin
      scl_p <= {scl_p[1:0], scl_i};
      sda_p <= {sda_p[1:0], sda_i};
    end
  end

  assign sda_bit   = sda_p[1];
  assign scl_rise  = scl_p[1] & ~scl_p[2];
  assign scl_fall  = ~scl_p[1] & scl_p[2];
  assign start_det = scl_p[1] & scl_p[2] & ~sda_p[1] & sda_p[2];
  assign stop_det  = scl_p[1] & scl_p[2] & sda_p[1] & ~sda_p[2];
  assign rx_byte   = {shift, sda_bit};

  always_comb begin
    cur_reg    = regs[ptr[AW-1:0]];
    tx_byte    = byte_idx ? cur_reg[7:0] : {ptr, cur_reg[8]};
    tx_bit_idx = 3'd7 - bit_cnt[2:0];
  end

  always_comb begin
    dbg_rd_data = '0;
    if (dbg_rd_addr <= REG_LAST)
      dbg_rd_data = regs[dbg_rd_addr[AW-1:0]];
  end

  always_ff @(posedge board_clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      rw        <= 1'b0;
      d8        <= 1'b0;
      ptr       <= '0;
      byte_idx  <= 1'b0;
      sda_oe    <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
      for (int unsigned i = 0; i < REG_COUNT; i++)
        regs[i] <= '0;
    end else begin
      wr_strobe <= 1'b0;
      if (stop_det) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else if (start_det) begin
        state   <= DEV_ADDR;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          DEV_ADDR: begin
            if (scl_rise) begin
              shift   <= {shift[5:0], sda_bit};
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                if (rx_byte[7:1] == DEVICE_ADDR) begin
                  rw    <= rx_byte[0];
                  busy  <= 1'b1;
                  state <= DEV_ACK;
                end else begin
                  state <= IGNORE;
                end
              end
            end
          end
          // ACK phases: first SCL fall pulls SDA, second fall releases and moves on.
          DEV_ACK: begin
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
              end else begin
                bit_cnt <= '0;
                if (rw) begin
                  byte_idx <= 1'b0;
                  sda_oe   <= ~ptr[6];
                  state    <= RD_BYTE;
                end else begin
                  sda_oe <= 1'b0;
                  state  <= WR_B0;
                end
              end
            end
          end
          WR_B0: begin
            if (scl_rise) begin
              shift   <= {shift[5:0], sda_bit};
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                if (rx_byte[7:1] <= REG_LAST) begin
                  ptr   <= rx_byte[7:1];
                  d8    <= rx_byte[0];
                  state <= ACK0;
                end else begin
                  state <= IGNORE;
                end
              end
            end
          end
          ACK0: begin
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
              end else begin
                sda_oe  <= 1'b0;
                bit_cnt <= '0;
                state   <= WR_B1;
              end
            end
          end
          WR_B1: begin
            if (scl_rise) begin
              shift   <= {shift[5:0], sda_bit};
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                regs[ptr[AW-1:0]] <= {d8, rx_byte};
                wr_strobe         <= 1'b1;
                wr_addr           <= ptr;
                wr_data           <= {d8, rx_byte};
                state             <= ACK1;
              end
            end
          end
          ACK1: begin
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
              end else begin
                sda_oe <= 1'b0;
                state  <= IGNORE;
              end
            end
          end
          // Bit 7 of a byte is driven on the fall that ends the preceding ACK bit.
          RD_BYTE: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt[3]) begin
                sda_oe <= 1'b0;
                state  <= RD_MACK;
              end else begin
                sda_oe <= ~tx_byte[tx_bit_idx];
              end
            end
          end
          RD_MACK: begin
            if (scl_rise) begin
              if (sda_bit) begin
                state <= IGNORE;
              end else begin
                bit_cnt <= '0;
                state   <= RD_BYTE;
                if (byte_idx) begin
                  byte_idx <= 1'b0;
                  ptr      <= (ptr == REG_LAST) ? '0 : ptr + 7'd1;
                end else begin
                  byte_idx <= 1'b1;
                end
              end
            end
          end
          IGNORE: sda_oe <= 1'b0;
          default: begin
            state  <= IDLE;
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_codec_target.sv
// Directed bench for i2c_codec_target: a bit-banged master feeds a scoreboard of
// expected ACK/read bytes and write strobes; monitors pop and compare.
module tb_i2c_codec_target;

  localparam int Q = 10;

  logic       board_clk = 1'b0;
  logic       reset_n   = 1'b0;
  logic       m_scl     = 1'b1;
  logic       m_oe      = 1'b0;
  logic [6:0] dbg_rd_addr = '0;
  logic       sda_line;
  logic       sda_oe;
  logic       wr_strobe;
  logic [6:0] wr_addr;
  logic [8:0] wr_data;
  logic       busy;
  logic [8:0] dbg_rd_data;

  int n_vec = 0;
  int n_err = 0;
  int strobe_cnt = 0;
  logic oe_seen = 1'b0;

  logic [7:0]  bus_exp_q[$];
  logic [7:0]  bus_act_q[$];
  string       bus_name_q[$];
  logic [15:0] strb_exp_q[$];
  string       strb_name_q[$];

  assign sda_line = ~(m_oe | sda_oe);

  always #5 board_clk = ~board_clk;

  i2c_codec_target #(.DEVICE_ADDR(7'h1A), .REG_COUNT(19)) dut (
    .board_clk  (board_clk),
    .reset_n    (reset_n),
    .scl_i      (m_scl),
    .sda_i      (sda_line),
    .sda_oe     (sda_oe),
    .wr_strobe  (wr_strobe),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .dbg_rd_addr(dbg_rd_addr),
    .dbg_rd_data(dbg_rd_data)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Bus-response monitor: pairs observed ACK/read bytes with the expected queue.
  always @(negedge board_clk) begin
    while (bus_exp_q.size() > 0 && bus_act_q.size() > 0)
      check(bus_name_q.pop_front(), {8'h00, bus_act_q.pop_front()}, {8'h00, bus_exp_q.pop_front()});
    if (sda_oe) oe_seen = 1'b1;
  end

  // Write-strobe monitor.
  always @(negedge board_clk) begin
    if (wr_strobe) begin
      strobe_cnt++;
      if (strb_exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_strobe: got addr %h data %h, expected no strobe", wr_addr, wr_data);
      end else begin
        check(strb_name_q.pop_front(), {wr_addr, wr_data}, strb_exp_q.pop_front());
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_q(input int n);
    repeat (n) @(negedge board_clk);
  endtask

  task automatic bus_bit(input logic b, output logic r);
    wait_q(Q);
    m_oe = ~b;
    wait_q(Q);
    m_scl = 1'b1;
    wait_q(Q);
    r = sda_line;
    wait_q(Q);
    m_scl = 1'b0;
  endtask

  task automatic i2c_start();
    wait_q(Q);
    m_oe = 1'b0;
    wait_q(Q);
    m_scl = 1'b1;
    wait_q(Q);
    m_oe = 1'b1;
    wait_q(Q);
    m_scl = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_q(Q);
    m_oe = 1'b1;
    wait_q(Q);
    m_scl = 1'b1;
    wait_q(Q);
    m_oe = 1'b0;
    wait_q(2 * Q);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string name);
    logic r;
    bus_exp_q.push_back({7'd0, exp_ack});
    bus_name_q.push_back(name);
    for (int i = 7; i >= 0; i--) bus_bit(b[i], r);
    bus_bit(1'b1, r);
    bus_act_q.push_back({7'd0, r});
  endtask

  task automatic read_byte(input logic [7:0] exp, input logic m_ack, input string name);
    logic r;
    logic [7:0] v;
    v = '0;
    bus_exp_q.push_back(exp);
    bus_name_q.push_back(name);
    for (int i = 0; i < 8; i++) begin
      bus_bit(1'b1, r);
      v = {v[6:0], r};
    end
    bus_bit(~m_ack, r);
    bus_act_q.push_back(v);
  endtask

  task automatic expect_strobe(input logic [6:0] a, input logic [8:0] d, input string name);
    strb_exp_q.push_back({a, d});
    strb_name_q.push_back(name);
  endtask

  task automatic check_reg(input logic [6:0] a, input logic [8:0] d, input string name);
    dbg_rd_addr = a;
    wait_q(1);
    check(name, {7'd0, dbg_rd_data}, {7'd0, d});
  endtask

  initial begin
    logic r;
    wait_q(5);
    check("rst_sda_oe", {15'd0, sda_oe}, 16'd0);
    check("rst_wr_strobe", {15'd0, wr_strobe}, 16'd0);
    check("rst_wr_addr_data", {wr_addr, wr_data}, 16'd0);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check_reg(7'h00, 9'h000, "rst_reg00");
    reset_n = 1'b1;
    wait_q(5);

    // Basic write of reg 0x06 = 0x067
    expect_strobe(7'h06, 9'h067, "t1_strobe");
    i2c_start();
    send_byte(8'h34, 1'b0, "t1_dev_ack");
    check("t1_busy_high", {15'd0, busy}, 16'd1);
    send_byte(8'h0C, 1'b0, "t1_b0_ack");
    send_byte(8'h67, 1'b0, "t1_b1_ack");
    i2c_stop();
    check("t1_busy_low", {15'd0, busy}, 16'd0);
    check_reg(7'h06, 9'h067, "t1_reg06");
    check("t1_strobe_cnt", 16'(strobe_cnt), 16'd1);

    // Wrong device address: no drive at all
    oe_seen = 1'b0;
    i2c_start();
    send_byte(8'h30, 1'b1, "t2_dev_nack");
    check("t2_busy_low", {15'd0, busy}, 16'd0);
    send_byte(8'h0C, 1'b1, "t2_b0_nack");
    send_byte(8'h67, 1'b1, "t2_b1_nack");
    i2c_stop();
    check("t2_oe_never", {15'd0, oe_seen}, 16'd0);
    check("t2_strobe_cnt", 16'(strobe_cnt), 16'd1);

    // Register address 0x13 is one past the bank
    i2c_start();
    send_byte(8'h34, 1'b0, "t3_dev_ack");
    send_byte(8'h27, 1'b1, "t3_b0_nack");
    send_byte(8'h55, 1'b1, "t3_b1_nack");
    i2c_stop();
    check("t3_strobe_cnt", 16'(strobe_cnt), 16'd1);
    check_reg(7'h06, 9'h067, "t3_reg06");
    check_reg(7'h12, 9'h000, "t3_reg12");
    check_reg(7'h13, 9'h000, "t3_reg13_oor");

    // Read-back with pointer wrap 0x12 -> 0x00
    expect_strobe(7'h12, 9'h1A5, "t4_strobe12");
    expect_strobe(7'h00, 9'h0F0, "t4_strobe00");
    i2c_start();
    send_byte(8'h34, 1'b0, "t4_w12_dev");
    send_byte(8'h25, 1'b0, "t4_w12_b0");
    send_byte(8'hA5, 1'b0, "t4_w12_b1");
    i2c_stop();
    i2c_start();
    send_byte(8'h34, 1'b0, "t4_w00_dev");
    send_byte(8'h00, 1'b0, "t4_w00_b0");
    send_byte(8'hF0, 1'b0, "t4_w00_b1");
    i2c_stop();
    i2c_start();
    send_byte(8'h34, 1'b0, "t4_ptr_dev");
    send_byte(8'h24, 1'b0, "t4_ptr_b0");
    i2c_start();
    send_byte(8'h35, 1'b0, "t4_rd_dev");
    read_byte(8'h25, 1'b1, "t4_rd0");
    read_byte(8'hA5, 1'b1, "t4_rd1");
    read_byte(8'h00, 1'b1, "t4_rd2");
    read_byte(8'hF0, 1'b0, "t4_rd3");
    i2c_stop();
    check("t4_strobe_cnt", 16'(strobe_cnt), 16'd3);
    check_reg(7'h12, 9'h1A5, "t4_reg12");

    // Reset in the middle of byte1 of a write
    i2c_start();
    send_byte(8'h34, 1'b0, "t5_dev_ack");
    send_byte(8'h0C, 1'b0, "t5_b0_ack");
    bus_bit(1'b0, r);
    bus_bit(1'b1, r);
    bus_bit(1'b1, r);
    bus_bit(1'b0, r);
    reset_n = 1'b0;
    #1;
    check("t5_rst_sda_oe", {15'd0, sda_oe}, 16'd0);
    check("t5_rst_busy", {15'd0, busy}, 16'd0);
    m_oe  = 1'b0;
    m_scl = 1'b1;
    wait_q(5);
    reset_n = 1'b1;
    wait_q(5);
    check("t5_wr_addr_data", {wr_addr, wr_data}, 16'd0);
    check_reg(7'h06, 9'h000, "t5_reg06");
    check("t5_strobe_cnt", 16'(strobe_cnt), 16'd3);

    // Third data byte NACKed, then repeated START
    expect_strobe(7'h06, 9'h067, "t6_strobe");
    i2c_start();
    send_byte(8'h34, 1'b0, "t6_dev_ack");
    send_byte(8'h0C, 1'b0, "t6_b0_ack");
    send_byte(8'h67, 1'b0, "t6_b1_ack");
    send_byte(8'h55, 1'b1, "t6_b2_nack");
    i2c_start();
    send_byte(8'h34, 1'b0, "t6_sr_dev_ack");
    check("t6_busy_high", {15'd0, busy}, 16'd1);
    i2c_stop();
    check("t6_strobe_cnt", 16'(strobe_cnt), 16'd4);
    check_reg(7'h06, 9'h067, "t6_reg06");

    wait_q(5);
    check("bus_queue_drained", 16'(bus_exp_q.size()), 16'd0);
    check("strobe_queue_drained", 16'(strb_exp_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
